// File: rtl/rf_alu_sequencer_pkg.sv
// Shared opcode, state and ALU control encodings for the RF/ALU sequencer.
package rf_alu_pkg;

   localparam logic [1:0] OP_ALU   = 2'b00;
   localparam logic [1:0] OP_LOADI = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

endpackage

// File: rtl/rf_alu_sequencer_if.sv
// Command and response handshakes between a command source and the sequencer.
interface rf_alu_sequencer_if #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int IMM_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [AW-1:0]    cmd_rd;
   logic [AW-1:0]    cmd_rs1;
   logic [AW-1:0]    cmd_rs2;
   logic [3:0]       cmd_alu_ctl;
   logic [IMM_W-1:0] cmd_imm;

   logic             resp_valid;
   logic             resp_ready;
   logic [DW-1:0]    resp_data;
   logic             resp_zero;
   logic             resp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_alu_ctl, cmd_imm, resp_ready,
      input  cmd_ready, resp_valid, resp_data, resp_zero, resp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_alu_ctl, cmd_imm, resp_ready,
      output cmd_ready, resp_valid, resp_data, resp_zero, resp_err
   );
endinterface

// File: rtl/rf_alu_sequencer.sv
// Sequences one command at a time through the register file and ALU and
// returns a response.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// EXEC   | ALU/READ operands presented, result captured at end of cycle
// WB     | one-cycle register-file write (suppressed for x0)
// RESP   | response held until resp_ready
module rf_alu_sequencer
   import rf_alu_pkg::*;
#(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int IMM_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_btn,
   rf_alu_sequencer_if.slave bus,
   output logic [AW-1:0]    rf_rs1,
   output logic [AW-1:0]    rf_rs2,
   output logic [AW-1:0]    rf_rd,
   output logic             rf_we,
   output logic [DW-1:0]    rf_wdata,
   input  logic [DW-1:0]    rf_rdata1,
   input  logic [DW-1:0]    rf_rdata2,
   output logic [3:0]       alu_ctl,
   input  logic [DW-1:0]    alu_result,
   input  logic             alu_zero,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   state_t        state, state_nxt;
   logic [1:0]    op_q;
   logic [DW-1:0] result_q;
   logic          zero_q;
   logic          accept;
   logic [DW-1:0] imm_ext;

   assign accept        = bus.cmd_valid && (state == S_IDLE);
   assign bus.cmd_ready = (state == S_IDLE);
   assign busy          = (state != S_IDLE);
   assign imm_ext       = {{(DW-IMM_W){1'b0}}, bus.cmd_imm};

   // State register.
   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) begin
            case (bus.cmd_op)
               OP_LOADI: state_nxt = S_WB;
               OP_RSVD:  state_nxt = S_RESP;
               default:  state_nxt = S_EXEC;
            endcase
         end
         S_EXEC:  state_nxt = (op_q == OP_ALU) ? S_WB : S_RESP;
         S_WB:    state_nxt = S_RESP;
         S_RESP:  if (bus.resp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath and output registers; rf_we is a one-cycle pulse into WB.
   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         op_q           <= '0;
         result_q       <= '0;
         zero_q         <= 1'b0;
         rf_rs1         <= '0;
         rf_rs2         <= '0;
         rf_rd          <= '0;
         rf_we          <= 1'b0;
         rf_wdata       <= '0;
         alu_ctl        <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_data  <= '0;
         bus.resp_zero  <= 1'b0;
         bus.resp_err   <= 1'b0;
         op_count       <= '0;
      end else begin
         rf_we <= 1'b0;
         case (state)
            S_IDLE: if (accept) begin
               op_q         <= bus.cmd_op;
               rf_rs1       <= bus.cmd_rs1;
               rf_rs2       <= bus.cmd_rs2;
               rf_rd        <= bus.cmd_rd;
               alu_ctl      <= bus.cmd_alu_ctl;
               bus.resp_err <= 1'b0;
               if (bus.cmd_op == OP_LOADI) begin
                  rf_we    <= (bus.cmd_rd != '0);
                  rf_wdata <= imm_ext;
                  result_q <= imm_ext;
                  zero_q   <= (imm_ext == '0);
               end else if (bus.cmd_op == OP_RSVD) begin
                  bus.resp_valid <= 1'b1;
                  bus.resp_data  <= '0;
                  bus.resp_zero  <= 1'b1;
                  bus.resp_err   <= 1'b1;
               end
            end
            S_EXEC: begin
               if (op_q == OP_ALU) begin
                  result_q <= alu_result;
                  zero_q   <= alu_zero;
                  rf_we    <= (rf_rd != '0);
                  rf_wdata <= alu_result;
               end else begin
                  bus.resp_valid <= 1'b1;
                  bus.resp_data  <= rf_rdata1;
                  bus.resp_zero  <= (rf_rdata1 == '0);
               end
            end
            S_WB: begin
               bus.resp_valid <= 1'b1;
               bus.resp_data  <= result_q;
               bus.resp_zero  <= zero_q;
            end
            S_RESP: if (bus.resp_ready) begin
               bus.resp_valid <= 1'b0;
               op_count       <= op_count + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Second read port feeds the ALU directly; the sequencer never samples it.
   logic unused_rdata2;
   assign unused_rdata2 = ^rf_rdata2;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Randomized self-checking bench: an external register file and ALU surround
// the sequencer, and an architectural register model predicts every response.
module tb_rf_alu_sequencer;
   import rf_alu_pkg::*;

   localparam int DW = 32, AW = 5, IMM_W = 8, CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_btn = 1'b0;
   logic [AW-1:0]    rf_rs1, rf_rs2, rf_rd;
   logic             rf_we;
   logic [DW-1:0]    rf_wdata, rf_rdata1, rf_rdata2, alu_result;
   logic             alu_zero;
   logic [3:0]       alu_ctl;
   logic             busy;
   logic [CNT_W-1:0] op_count;

   rf_alu_sequencer_if #(.DW(DW), .AW(AW), .IMM_W(IMM_W)) ifc ();

   rf_alu_sequencer #(.DW(DW), .AW(AW), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_btn(rst_btn), .bus(ifc),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd), .rf_we(rf_we),
      .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .alu_ctl(alu_ctl), .alu_result(alu_result), .alu_zero(alu_zero),
      .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
      case (ctl)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         default: return 32'h0;
      endcase
   endfunction

   // Environment: register file (x0 hardwired to zero) and combinational ALU.
   logic [31:0] rf_mem [32];
   int          we_cnt = 0;
   logic [4:0]  last_waddr;
   logic [31:0] last_wdata;

   assign rf_rdata1  = (rf_rs1 == '0) ? 32'h0 : rf_mem[rf_rs1];
   assign rf_rdata2  = (rf_rs2 == '0) ? 32'h0 : rf_mem[rf_rs2];
   assign alu_result = alu_fn(alu_ctl, rf_rdata1, rf_rdata2);
   assign alu_zero   = (alu_result == 32'h0);

   always @(posedge clk) begin
      if (rf_we) begin
         we_cnt++;
         last_waddr = rf_rd;
         last_wdata = rf_wdata;
         if (rf_rd != '0) rf_mem[rf_rd] = rf_wdata;
      end
   end

   // Reference model state.
   logic [31:0] ref_rf [32];
   int          exp_cnt = 0;
   int          n_chk = 0;
   int          n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_cmd(input logic [1:0] op, input int rd, input int rs1, input int rs2,
                          input logic [3:0] ctl, input logic [7:0] imm, input int hold);
      logic [31:0] exp_data;
      int          exp_lat;
      bit          exp_we;
      int          n;
      int          we0;
      exp_we = 1'b0;
      exp_data = 32'h0;
      case (op)
         OP_ALU: begin
            exp_data = alu_fn(ctl, ref_rf[rs1], ref_rf[rs2]);
            exp_lat = 3;
            exp_we = (rd != 0);
         end
         OP_LOADI: begin
            exp_data = {24'h0, imm};
            exp_lat = 2;
            exp_we = (rd != 0);
         end
         OP_READ: begin
            exp_data = ref_rf[rs1];
            exp_lat = 2;
         end
         default: exp_lat = 1;
      endcase

      @(negedge clk);
      check_eq("cmd_ready_idle", 32'(ifc.cmd_ready), 32'd1);
      ifc.cmd_valid   = 1'b1;
      ifc.cmd_op      = op;
      ifc.cmd_rd      = 5'(rd);
      ifc.cmd_rs1     = 5'(rs1);
      ifc.cmd_rs2     = 5'(rs2);
      ifc.cmd_alu_ctl = ctl;
      ifc.cmd_imm     = imm;
      ifc.resp_ready  = (hold == 0);
      we0 = we_cnt;
      @(posedge clk);
      #1 ifc.cmd_valid = 1'b0;

      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ifc.resp_valid && n < 12);
      check_eq("latency", 32'(n), 32'(exp_lat));
      if (op != OP_RSVD) begin
         check_eq("resp_data", ifc.resp_data, exp_data);
         check_eq("resp_zero", 32'(ifc.resp_zero), 32'(exp_data == 32'h0));
      end
      check_eq("resp_err", 32'(ifc.resp_err), 32'(op == OP_RSVD));
      check_eq("alu_ctl", 32'(alu_ctl), 32'(ctl));
      check_eq("cmd_ready_busy", 32'(ifc.cmd_ready), 32'd0);

      for (int i = 0; i < hold; i++) begin
         ifc.cmd_valid   = 1'b1;
         ifc.cmd_op      = OP_LOADI;
         ifc.cmd_rd      = 5'd5;
         ifc.cmd_imm     = 8'hAA;
         @(negedge clk);
         check_eq("hold_valid", 32'(ifc.resp_valid), 32'd1);
         check_eq("hold_data", ifc.resp_data, exp_data);
         check_eq("hold_zero", 32'(ifc.resp_zero), 32'(exp_data == 32'h0));
         check_eq("hold_ready", 32'(ifc.cmd_ready), 32'd0);
         check_eq("hold_count", 32'(op_count), 32'(exp_cnt));
      end
      ifc.cmd_valid  = 1'b0;
      ifc.resp_ready = 1'b1;
      @(negedge clk);
      exp_cnt = (exp_cnt + 1) % 256;
      check_eq("resp_drop", 32'(ifc.resp_valid), 32'd0);
      check_eq("busy_idle", 32'(busy), 32'd0);
      check_eq("op_count", 32'(op_count), 32'(exp_cnt));
      check_eq("we_pulses", 32'(we_cnt - we0), 32'(exp_we));
      if (exp_we) begin
         check_eq("w_addr", 32'(last_waddr), 32'(rd));
         check_eq("w_data", last_wdata, exp_data);
         ref_rf[rd] = exp_data;
      end
   endtask

   logic [3:0] ctl_tab [4];

   initial begin
      ctl_tab[0] = ALU_AND; ctl_tab[1] = ALU_OR; ctl_tab[2] = ALU_ADD; ctl_tab[3] = ALU_SUB;
      for (int i = 0; i < 32; i++) begin
         rf_mem[i] = 32'h0;
         ref_rf[i] = 32'h0;
      end
      ifc.cmd_valid = 1'b0; ifc.cmd_op = '0; ifc.cmd_rd = '0; ifc.cmd_rs1 = '0;
      ifc.cmd_rs2 = '0; ifc.cmd_alu_ctl = '0; ifc.cmd_imm = '0; ifc.resp_ready = 1'b1;

      repeat (3) @(negedge clk);
      check_eq("rst_we", 32'(rf_we), 32'd0);
      check_eq("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
      check_eq("rst_count", 32'(op_count), 32'd0);
      check_eq("rst_wdata", rf_wdata, 32'h0);
      check_eq("rst_alu_ctl", 32'(alu_ctl), 32'd0);
      check_eq("rst_resp_data", ifc.resp_data, 32'h0);
      rst_btn = 1'b1;
      @(negedge clk);
      check_eq("rst_ready", 32'(ifc.cmd_ready), 32'd1);

      // Reset during the WB cycle of a LOADI must not corrupt x3.
      run_cmd(OP_LOADI, 3, 0, 0, 4'h0, 8'h11, 0);
      @(negedge clk);
      ifc.cmd_valid = 1'b1; ifc.cmd_op = OP_LOADI; ifc.cmd_rd = 5'd3; ifc.cmd_imm = 8'h77;
      @(posedge clk);
      #1 ifc.cmd_valid = 1'b0;
      @(negedge clk);
      check_eq("wb_we_pre", 32'(rf_we), 32'd1);
      rst_btn = 1'b0;
      #1;
      check_eq("mid_rst_we", 32'(rf_we), 32'd0);
      check_eq("mid_rst_valid", 32'(ifc.resp_valid), 32'd0);
      check_eq("mid_rst_count", 32'(op_count), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      exp_cnt = 0;
      @(negedge clk);
      rst_btn = 1'b1;
      run_cmd(OP_READ, 0, 3, 0, 4'h0, 8'h0, 0);

      run_cmd(OP_LOADI, 1, 0, 0, 4'h0, 8'h05, 0);
      run_cmd(OP_LOADI, 2, 0, 0, 4'h0, 8'h03, 0);
      run_cmd(OP_ALU, 3, 1, 2, ALU_ADD, 8'h0, 0);
      run_cmd(OP_READ, 0, 3, 0, 4'h0, 8'h0, 0);
      check_eq("x3_sum", ref_rf[3], 32'h8);
      run_cmd(OP_ALU, 4, 1, 1, ALU_SUB, 8'h0, 5);
      run_cmd(OP_READ, 0, 5, 0, 4'h0, 8'h0, 0);
      run_cmd(OP_LOADI, 0, 0, 0, 4'h0, 8'hFF, 0);
      run_cmd(OP_RSVD, 6, 1, 2, ALU_OR, 8'h12, 0);
      run_cmd(OP_LOADI, 6, 0, 0, 4'h0, 8'h00, 0);

      for (int i = 0; i < 80; i++) begin
         run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), ctl_tab[$urandom_range(0, 3)], 8'($urandom),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end

      for (int i = 0; i < 256; i++) begin
         run_cmd(OP_READ, 0, $urandom_range(0, 7), 0, 4'h0, 8'h0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/rf_alu_sequencer.md
Name: rf_alu_sequencer

Overview:
Command-driven controller that sequences the register file and ALU datapath. It accepts one command at a time over a valid/ready handshake and performs one of three operations: a register-to-register ALU operation, an immediate load, or a register read. For each command it drives the register-file addresses and write enable and the ALU control, captures the ALU result, writes it back, and returns a response over a second valid/ready handshake. It replaces switch-driven ad-hoc sequencing of the RF/ALU pair in the top level.

Parameters:
DW, 32, datapath width (register-file data and ALU result)
AW, 5, register address width
IMM_W, 8, immediate width; zero-extended to DW on load
CNT_W, 8, width of the completed-command counter

Ports:
clk  in  1  system clock, rising edge
rst_btn  in  1  asynchronous reset, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  00=ALU, 01=LOADI, 10=READ, 11=reserved
cmd_rd  in  AW  destination register
cmd_rs1  in  AW  source register 1
cmd_rs2  in  AW  source register 2
cmd_alu_ctl  in  4  ALU control code, passed through unchanged
cmd_imm  in  IMM_W  immediate for LOADI
rf_rs1  out  AW  register-file read address 1
rf_rs2  out  AW  register-file read address 2
rf_rd  out  AW  register-file write address
rf_we  out  1  register-file write enable
rf_wdata  out  DW  register-file write data
rf_rdata1  in  DW  register-file read data 1 (combinational)
rf_rdata2  in  DW  register-file read data 2 (combinational)
alu_ctl  out  4  ALU control
alu_result  in  DW  ALU result (combinational)
alu_zero  in  1  ALU zero flag
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts the response
resp_data  out  DW  ALU result, loaded immediate, or read value
resp_zero  out  1  resp_data == 0
resp_err  out  1  reserved opcode was received
busy  out  1  state != IDLE
op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
- All outputs are registered except cmd_ready (= state==IDLE) and busy.
- Reset (rst_btn=0, asynchronous, valid at any point including mid-command):
  - state=IDLE
  - rf_we=0, resp_valid=0
  - all address, data, alu_ctl and resp fields = 0
  - op_count=0
  - Any in-flight command is discarded; no write occurs after reset asserts.
- Command accept: cmd_valid && cmd_ready at rising edge T. On this edge the controller latches op, rd, alu_ctl and imm, and loads rs1/rs2 onto rf_rs1/rf_rs2.
- States and transitions:
  - IDLE: on accept, ALU or READ -> EXEC; LOADI -> WB; reserved -> RESP with resp_err=1.
  - EXEC (cycle T+1): alu_ctl drives the latched code. At the end of the cycle the controller captures alu_result/alu_zero (ALU) or rf_rdata1 (READ) into the result register. ALU -> WB; READ -> RESP.
  - WB (one cycle): rf_we=1, rf_rd=latched rd, rf_wdata=result (ALU) or zero-extended imm (LOADI). If rd==0, rf_we stays 0 (x0 is never written) but the response is still issued. -> RESP.
  - RESP: resp_valid=1 with resp_data, resp_zero and resp_err held stable until resp_ready. On the handshake edge: op_count increments, resp_valid drops, state -> IDLE.
- Latency from accept edge to the first resp_valid cycle:
  - ALU: 3 cycles (EXEC, WB, RESP)
  - LOADI: 2 cycles
  - READ: 2 cycles
  - reserved: 1 cycle
- If resp_ready is held high, RESP lasts exactly one cycle, so back-to-back ALU commands issue every 4 cycles.
- cmd_valid outside IDLE is ignored; cmd_ready=0 there and command inputs need not stay stable.
- rf_we is high only in WB and only for one cycle per command.
- alu_ctl holds its value after EXEC until the next accept.
- op_count wraps 2^CNT_W-1 -> 0 with no flag.
- resp_err clears on the next accepted command.
- resp_zero is computed on resp_data, not taken from alu_zero, for LOADI/READ; for ALU it equals the captured alu_zero.

Decomposition:
- Shared package rf_alu_pkg holds:
  - opcode constants OP_ALU, OP_LOADI, OP_READ, OP_RSVD
  - state encoding S_IDLE, S_EXEC, S_WB, S_RESP
  - ALU control code constants ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, used by the bench and the top level
- Single module, no sub-module. The FSM and datapath registers are small enough to keep together.

Test Plan:
- Reset mid-WB: assert rst_btn=0 during WB of a LOADI to x3 -> rf_we falls immediately, resp_valid=0, op_count=0, and a later READ x3 returns the pre-reset value.
- LOADI x1=0x05, then LOADI x2=0x03 -> each write takes one rf_we cycle with rf_wdata=0x00000005 / 0x00000003; resp_valid 2 cycles after accept; op_count=2.
- ALU ADD x3=x1+x2 (ctl 0010), resp_ready=1 -> EXEC, WB with rf_wdata=0x8, resp_data=0x8, resp_zero=0, resp_valid exactly 3 cycles after accept; READ x3 then returns 0x8.
- ALU SUB x4=x1-x1 with resp_ready=0 for 5 cycles -> resp_valid stays high with resp_data=0 and resp_zero=1 held stable; cmd_ready=0 throughout; the second cmd_valid is ignored; op_count increments only on the ready edge.
- LOADI x0=0xFF -> rf_we never asserts, resp_data=0xFF, op_count increments; cmd_op=11 -> resp_err=1 after 1 cycle with no rf_we.
- Issue 256 READ commands back-to-back -> op_count wraps 0xFF -> 0x00; each response arrives 2 cycles after accept.
